wdg_feed_ctrl: RTL and testbench
================================

# wdg_feed_ctrl

- APB4 master sequencer that initialises and services one watchdog slave on the peripheral bus.
- At start-up it unlocks the watchdog and writes its prescaler, compare and control registers.
- Afterwards it aggregates heartbeat pulses from `NUM_REQ` software/hardware requesters and performs the keyed feed sequence only when every requester has checked in.
- It sits between the system's liveness sources and the watchdog, so no single requester can keep the watchdog alive alone.

## Interface
- `NUM_REQ`, 4: number of heartbeat requesters (1..16).
- `BASE_ADDR`, 32'h0: watchdog base address; register address = `BASE_ADDR` + offset.
- `PSCR_INIT`, 32'd2: prescaler value written during init.
- `CMP_INIT`, 32'hFFFF: compare value written during init.
- `CTRL_INIT`, 32'h5: control value written during init (bit0 ovie, bit1 etr, bit2 en).

Ports:
- `pclk` in 1: single clock.
- `presetn` in 1: reset, synchronous, active-low.
- `init_i` in 1: pulse; start the init sequence.
- `hb_i` in `NUM_REQ`: heartbeat pulses, one bit per requester.
- `irq_i` in 1: watchdog overflow flag (used only with the macro).
- `init_done_o` out 1: init completed without error.
- `busy_o` out 1: a sequence is in progress.
- `hb_seen_o` out `NUM_REQ`: sticky heartbeat mask.
- `err_o` out 1: sticky; a transfer returned `pslverr`.
- `ovif_o` out 1: last STAT bit0 read (macro only).
- `paddr_o` out 32, `psel_o` out 1, `penable_o` out 1, `pwrite_o` out 1, `pwdata_o` out 32: APB4 master request.
- `prdata_i` in 32, `pready_i` in 1, `pslverr_i` in 1: APB4 master response.

## Operation
- **Register offsets:** CTRL 0x00, PSCR 0x04, CNT 0x08, CMP 0x0C, STAT 0x10, KEY 0x14, FEED 0x18. Key value 32'h5F37_59DF.
- **Key rule:** any write to a non-KEY register re-locks the watchdog, so every protected write is preceded by its own KEY write.
- **Init sequence** (6 writes): KEY, PSCR←`PSCR_INIT`, KEY, CMP←`CMP_INIT`, KEY, CTRL←`CTRL_INIT`.
- **Feed sequence** (4 writes): KEY, FEED←1, KEY, FEED←0. FEED must return to 0 or the counter stays cleared.
- **Bus FSM:** IDLE → SETUP (`psel`=1, `penable`=0) → ACCESS (`psel`=1, `penable`=1, held until `pready_i`).
  - After ACCESS completes: SETUP for the next step of the sequence, or IDLE after the last step.
  - `paddr_o`, `pwrite_o` and `pwdata_o` are stable from SETUP through ACCESS.
  - `paddr_o` and `pwdata_o` are 0 in IDLE.
- **Step counter:** 3 bits, indexes the active sequence; a sequence-select register records which sequence is running.
- **Arbitration in IDLE** (fixed priority): init_i > STAT read (macro only) > feed. Feed is eligible only when `init_done_o`=1 and `hb_seen_o` is all-ones.
- **init_i handling:** ignored while busy. Accepted in IDLE even after init has completed, which re-initialises; `init_done_o` clears when the sequence starts.
- **Heartbeat mask:** `hb_seen_o[i]` sets on `hb_i[i]`. The whole mask clears in the cycle the feed sequence is launched; a heartbeat in that same cycle wins and stays set.
- **Error:** `pslverr_i`=1 on a completing ACCESS sets `err_o`, aborts the sequence and returns to IDLE.
  - If the aborted sequence was init, `init_done_o` stays 0.
  - `err_o` clears only on `init_i` acceptance.
- **`init_done_o`:** sets when the final CTRL write completes without error.

## Timing
- **Reset:** all outputs 0 and FSM in IDLE one edge after `presetn` is sampled low. An in-flight transfer is dropped: `psel_o` and `penable_o` fall after that edge.
- **Transfer length:** each transfer is 2 cycles minimum, plus one cycle per wait state.
- **Init:** with zero wait states, `init_i` sampled at edge N → first SETUP at N+1 → `init_done_o`=1 at N+13.
- **Feed:** with zero wait states, 8 cycles from launch to IDLE.
- **`busy_o`:** 1 from the first SETUP through the last ACCESS.
- **Heartbeats:** `hb_i` is sampled every cycle, including while busy; no pulse is lost.

## Configuration
- `WDG_FEED_CTRL_STAT_CLR_EN` defined:
  - `irq_i`=1 in IDLE with `init_done_o`=1 launches a one-transfer read of STAT.
  - Reading STAT clears the watchdog flag. `ovif_o` ← `prdata_i[0]` on completion.
  - `irq_i` is ignored while a STAT read is active.
- Not defined: `irq_i` is unused, `ovif_o` is tied to 0, and no read transfers are ever issued (`pwrite_o`=1 whenever `psel_o`=1).

## Structure
- **Shared package `wdg_feed_pkg`:**
  - register offset constants and the key constant (shared with the watchdog define file);
  - `typedef enum {IDLE, SETUP, ACCESS}` for the bus FSM;
  - `typedef enum {SEQ_INIT, SEQ_FEED, SEQ_STAT}` for sequence select;
  - the step-table function mapping (sequence, step) to {addr offset, data, write, last}.
- **Sub-module `apb4_mst_xfer`:** one APB4 transfer engine (request/accept, done, error). The sequencer above it holds the tables, step counter and heartbeat mask.

## Test plan
- **Init, zero wait:** reset, `init_i` pulse → writes to offsets 0x14,0x04,0x14,0x0C,0x14,0x00 with data 5F3759DF,2,5F3759DF,FFFF,5F3759DF,5; `init_done_o`=1 exactly 13 cycles after sampling.
- **Feed gating:** `NUM_REQ`=4, heartbeats on req 0,1,2 only → no transfers. Then req 3 → feed writes 0x14,0x18(1),0x14,0x18(0); mask returns to 0.
- **Heartbeat collision:** `hb_i[2]` pulses in the feed-launch cycle → after launch `hb_seen_o`=4'b0100.
- **Wait states and error:** `pready_i` low for 3 cycles on the PSCR write → address and data held stable throughout. Then `pslverr_i` on the CMP write → `err_o`=1, IDLE, `init_done_o`=0, no CTRL write.
- **Reset mid-sequence:** `presetn` low during the feed ACCESS → `psel_o`=0 the next cycle, mask cleared, `init_done_o`=0.
- **With `WDG_FEED_CTRL_STAT_CLR_EN`:** `irq_i`=1 after init, `prdata_i`=1 → one read at offset 0x10, `ovif_o`=1. A simultaneous full heartbeat mask → the read goes first, then the feed.

Source files
------------

// File: rtl/wdg_feed_ctrl_pkg.sv
// Shared definitions for the watchdog feed controller: watchdog register map,
// unlock key, bus/sequence state types and the sequence step table.
package wdg_feed_pkg;

   // Watchdog register offsets (shared with the watchdog define file)
   localparam logic [31:0] OFS_CTRL = 32'h00;
   localparam logic [31:0] OFS_PSCR = 32'h04;
   localparam logic [31:0] OFS_CNT  = 32'h08;
   localparam logic [31:0] OFS_CMP  = 32'h0C;
   localparam logic [31:0] OFS_STAT = 32'h10;
   localparam logic [31:0] OFS_KEY  = 32'h14;
   localparam logic [31:0] OFS_FEED = 32'h18;

   // Unlock key; every write to a non-KEY register re-locks the watchdog
   localparam logic [31:0] WDG_KEY  = 32'h5F37_59DF;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} bus_state_e;

   typedef enum logic [1:0] {SEQ_INIT, SEQ_FEED, SEQ_STAT} seq_sel_e;

   typedef struct packed {
      logic [31:0] ofs;
      logic [31:0] data;
      logic        write;
      logic        last;
   } step_t;

   // Final step of each sequence: init has 6 writes, feed 4, STAT read 1
   function automatic logic step_is_last(seq_sel_e seq, logic [2:0] step);
      case (seq)
         SEQ_INIT: return step == 3'd5;
         SEQ_FEED: return step == 3'd3;
         default:  return 1'b1;
      endcase
   endfunction

   // Maps (sequence, step) to one bus transfer. Even steps of init and feed
   // are KEY writes, so each protected write gets its own unlock.
   function automatic step_t step_entry(seq_sel_e    seq,
                                        logic [2:0]  step,
                                        logic [31:0] pscr,
                                        logic [31:0] cmp,
                                        logic [31:0] ctrl);
      step_t s;
      s.ofs   = OFS_KEY;
      s.data  = WDG_KEY;
      s.write = 1'b1;
      s.last  = step_is_last(seq, step);
      case (seq)
         SEQ_INIT: begin
            case (step)
               3'd1:    begin s.ofs = OFS_PSCR; s.data = pscr; end
               3'd3:    begin s.ofs = OFS_CMP;  s.data = cmp;  end
               3'd5:    begin s.ofs = OFS_CTRL; s.data = ctrl; end
               default: ;
            endcase
         end
         SEQ_FEED: begin
            // FEED must be pulsed back to 0 or the counter stays cleared
            case (step)
               3'd1:    begin s.ofs = OFS_FEED; s.data = 32'd1; end
               3'd3:    begin s.ofs = OFS_FEED; s.data = 32'd0; end
               default: ;
            endcase
         end
         default: begin
            s.ofs   = OFS_STAT;
            s.data  = '0;
            s.write = 1'b0;
         end
      endcase
      return s;
   endfunction

endpackage

// File: rtl/wdg_feed_ctrl_if.sv
// APB4 request/response bundle between the feed controller (master) and the
// watchdog slave.
interface wdg_feed_ctrl_if;
   logic [31:0] paddr_o;
   logic        psel_o;
   logic        penable_o;
   logic        pwrite_o;
   logic [31:0] pwdata_o;
   logic [31:0] prdata_i;
   logic        pready_i;
   logic        pslverr_i;

   modport master (
      output paddr_o, psel_o, penable_o, pwrite_o, pwdata_o,
      input  prdata_i, pready_i, pslverr_i
   );

   modport slave (
      input  paddr_o, psel_o, penable_o, pwrite_o, pwdata_o,
      output prdata_i, pready_i, pslverr_i
   );
endinterface

// File: rtl/wdg_feed_ctrl_apb4_mst_xfer.sv
// Single APB4 transfer engine. A request is taken in IDLE, or at the
// completing ACCESS so sequence steps run back to back (ACCESS -> SETUP).
// Address, direction and write data are held from SETUP through ACCESS.
module apb4_mst_xfer
   import wdg_feed_pkg::*;
(
   input  logic            pclk,
   input  logic            presetn,
   input  logic            i_req,
   input  logic [31:0]     i_addr,
   input  logic [31:0]     i_wdata,
   input  logic            i_write,
   output logic            o_done,
   output logic            o_err,
   wdg_feed_ctrl_if.master bus
);

   bus_state_e  r_state;
   logic        r_psel;
   logic        r_penable;
   logic        r_write;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic        w_done;

   assign w_done = (r_state == ACCESS) && bus.pready_i;
   assign o_done = w_done;
   assign o_err  = w_done && bus.pslverr_i;

   // Bus FSM with registered APB outputs; address/data forced to 0 in IDLE
   always_ff @(posedge pclk) begin
      // NOTE: state uses non-blocking assignments so every register here sees pre-edge values.
      if (!presetn) begin
         r_state   <= IDLE;
         r_psel    <= 1'b0;
         r_penable <= 1'b0;
         r_write   <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_req) begin
                  r_state   <= SETUP;
                  r_psel    <= 1'b1;
                  r_penable <= 1'b0;
                  r_addr    <= i_addr;
                  r_wdata   <= i_wdata;
                  r_write   <= i_write;
               end
            end
            SETUP: begin
               r_state   <= ACCESS;
               r_penable <= 1'b1;
            end
            ACCESS: begin
               if (bus.pready_i) begin
                  if (i_req && !bus.pslverr_i) begin
                     r_state   <= SETUP;
                     r_penable <= 1'b0;
                     r_addr    <= i_addr;
                     r_wdata   <= i_wdata;
                     r_write   <= i_write;
                  end else begin
                     r_state   <= IDLE;
                     r_psel    <= 1'b0;
                     r_penable <= 1'b0;
                     r_write   <= 1'b0;
                     r_addr    <= '0;
                     r_wdata   <= '0;
                  end
               end
            end
            default: begin
               r_state   <= IDLE;
               r_psel    <= 1'b0;
               r_penable <= 1'b0;
            end
         endcase
      end
   end

   assign bus.psel_o    = r_psel;
   assign bus.penable_o = r_penable;
   assign bus.pwrite_o  = r_write;
   assign bus.paddr_o   = r_addr;
   assign bus.pwdata_o  = r_wdata;

endmodule

// File: rtl/wdg_feed_ctrl.sv
// Watchdog feed controller: unlocks and programs the watchdog after init_i,
// then feeds it with the keyed sequence only once every requester has sent a
// heartbeat. Optional feature macro WDG_FEED_CTRL_STAT_CLR_EN adds a STAT
// read (flag clear) triggered by irq_i.
module wdg_feed_ctrl
   import wdg_feed_pkg::*;
#(
   parameter int          NUM_REQ   = 4,
   parameter logic [31:0] BASE_ADDR = 32'h0,
   parameter logic [31:0] PSCR_INIT = 32'd2,
   parameter logic [31:0] CMP_INIT  = 32'hFFFF,
   parameter logic [31:0] CTRL_INIT = 32'h5
)(
   input  logic               pclk,
   input  logic               presetn,
   input  logic               init_i,
   input  logic [NUM_REQ-1:0] hb_i,
   input  logic               irq_i,
   output logic               init_done_o,
   output logic               busy_o,
   output logic [NUM_REQ-1:0] hb_seen_o,
   output logic               err_o,
   output logic               ovif_o,
   wdg_feed_ctrl_if.master    bus
);

   logic               r_active;
   seq_sel_e           r_seq;
   logic [2:0]         r_step;
   logic [NUM_REQ-1:0] r_hb_seen;
   logic               r_err;
   logic               r_init_done;

   logic               w_done;
   logic               w_xfer_err;
   logic               w_cur_last;
   logic               w_req;
   logic               w_idle;
   logic               w_launch_init;
   logic               w_launch_stat;
   logic               w_launch_feed;
   logic [2:0]         w_next_idx;
   step_t              w_next;

   // On completion the engine needs the following step right away, so the
   // table is indexed one ahead in that cycle.
   assign w_cur_last = step_is_last(r_seq, r_step);
   assign w_next_idx = w_done ? r_step + 3'd1 : r_step;
   assign w_next     = step_entry(r_seq, w_next_idx, PSCR_INIT, CMP_INIT, CTRL_INIT);
   assign w_req      = r_active && !(w_done && (w_cur_last || w_xfer_err));

   // Fixed priority in IDLE: init > STAT read > feed
   assign w_idle        = !r_active;
   assign w_launch_init = w_idle && init_i;
   assign w_launch_feed = w_idle && !init_i && !w_launch_stat && r_init_done && (&r_hb_seen);

   apb4_mst_xfer u_xfer (
      .pclk    (pclk),
      .presetn (presetn),
      .i_req   (w_req),
      .i_addr  (BASE_ADDR + w_next.ofs),
      .i_wdata (w_next.data),
      .i_write (w_next.write),
      .o_done  (w_done),
      .o_err   (w_xfer_err),
      .bus     (bus)
   );

   // Sequencer: launch, step advance, abort on error, heartbeat aggregation
   always_ff @(posedge pclk) begin
      if (!presetn) begin
         r_active    <= 1'b0;
         r_seq       <= SEQ_INIT;
         r_step      <= '0;
         r_hb_seen   <= '0;
         r_err       <= 1'b0;
         r_init_done <= 1'b0;
      end else begin
         // A heartbeat arriving in the launch cycle survives the clear
         r_hb_seen <= (w_launch_feed ? '0 : r_hb_seen) | hb_i;
         if (w_launch_init) begin
            r_active    <= 1'b1;
            r_seq       <= SEQ_INIT;
            r_step      <= '0;
            r_err       <= 1'b0;
            r_init_done <= 1'b0;
         end else if (w_launch_stat) begin
            r_active <= 1'b1;
            r_seq    <= SEQ_STAT;
            r_step   <= '0;
         end else if (w_launch_feed) begin
            r_active <= 1'b1;
            r_seq    <= SEQ_FEED;
            r_step   <= '0;
         end else if (w_done) begin
            if (w_xfer_err) begin
               r_err    <= 1'b1;
               r_active <= 1'b0;
            end else if (w_cur_last) begin
               r_active <= 1'b0;
               if (r_seq == SEQ_INIT) r_init_done <= 1'b1;
            end else begin
               r_step <= r_step + 3'd1;
            end
         end
      end
   end

`ifdef WDG_FEED_CTRL_STAT_CLR_EN
   logic r_ovif;
   logic w_unused;

   assign w_launch_stat = w_idle && !init_i && irq_i && r_init_done;

   // Capture the overflow flag from the completing STAT read
   always_ff @(posedge pclk) begin
      if (!presetn) begin
         r_ovif <= 1'b0;
      end else if (w_done && (r_seq == SEQ_STAT)) begin
         r_ovif <= bus.prdata_i[0];
      end
   end

   assign ovif_o   = r_ovif;
   assign w_unused = ^{w_next.last, bus.prdata_i[31:1]};
`else
   logic w_unused;

   assign w_launch_stat = 1'b0;
   assign ovif_o        = 1'b0;
   assign w_unused      = ^{w_next.last, irq_i, bus.prdata_i};
`endif

   assign busy_o      = bus.psel_o;
   assign init_done_o = r_init_done;
   assign hb_seen_o   = r_hb_seen;
   assign err_o       = r_err;

endmodule

// File: tb/tb_wdg_feed_ctrl.sv
// Bench for wdg_feed_ctrl: directed stimulus pushes expected APB transfers
// into a scoreboard queue; the bus agent models the watchdog slave and pops
// and compares on every completing ACCESS.
module tb_wdg_feed_ctrl;
   import wdg_feed_pkg::*;

   localparam int          NUM_REQ = 4;
   localparam logic [31:0] BASE    = 32'h0000_1000;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic        write;
   } xfer_t;

   logic               clk      = 1'b0;
   logic               presetn  = 1'b0;
   logic               init_i   = 1'b0;
   logic               irq_i    = 1'b0;
   logic [NUM_REQ-1:0] hb_i     = '0;
   logic               init_done_o;
   logic               busy_o;
   logic [NUM_REQ-1:0] hb_seen_o;
   logic               err_o;
   logic               ovif_o;

   logic [31:0] wait_addr = '1;
   logic [31:0] err_addr  = '1;
   logic [31:0] rd_data   = '0;

   xfer_t sb_q[$];
   int    checks   = 0;
   int    failures = 0;

   wdg_feed_ctrl_if bus_if ();

   wdg_feed_ctrl #(
      .NUM_REQ   (NUM_REQ),
      .BASE_ADDR (BASE)
   ) dut (
      .pclk        (clk),
      .presetn     (presetn),
      .init_i      (init_i),
      .hb_i        (hb_i),
      .irq_i       (irq_i),
      .init_done_o (init_done_o),
      .busy_o      (busy_o),
      .hb_seen_o   (hb_seen_o),
      .err_o       (err_o),
      .ovif_o      (ovif_o),
      .bus         (bus_if)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] ofs, input logic [31:0] data, input logic wr);
      xfer_t x;
      x.addr  = BASE + ofs;
      x.data  = data;
      x.write = wr;
      sb_q.push_back(x);
   endtask

   task automatic push_init();
      push(OFS_KEY, WDG_KEY, 1'b1);
      push(OFS_PSCR, 32'd2, 1'b1);
      push(OFS_KEY, WDG_KEY, 1'b1);
      push(OFS_CMP, 32'hFFFF, 1'b1);
      push(OFS_KEY, WDG_KEY, 1'b1);
      push(OFS_CTRL, 32'h5, 1'b1);
   endtask

   task automatic push_feed();
      push(OFS_KEY, WDG_KEY, 1'b1);
      push(OFS_FEED, 32'd1, 1'b1);
      push(OFS_KEY, WDG_KEY, 1'b1);
      push(OFS_FEED, 32'd0, 1'b1);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_init();
      @(negedge clk);
      init_i = 1'b1;
      tick();
      init_i = 1'b0;
   endtask

   // Bounded wait until the bus is idle and all expected transfers are seen
   task automatic wait_idle(input string name, input int max);
      int n;
      n = 0;
      tick();
      while ((busy_o || sb_q.size() != 0) && n < max) begin
         tick();
         n++;
      end
      check({name, "_outstanding"}, sb_q.size(), 32'd0);
      sb_q.delete();
   endtask

   // Watchdog slave model and scoreboard monitor, evaluated on the falling edge
   initial begin
      int          wcnt;
      logic [31:0] s_addr;
      logic [31:0] s_data;
      xfer_t       e;
      wcnt   = 0;
      s_addr = '0;
      s_data = '0;
      // NOTE: bench drives DUT inputs with blocking assignments away from the active edge.
      bus_if.pready_i  = 1'b0;
      bus_if.pslverr_i = 1'b0;
      bus_if.prdata_i  = '0;
      forever begin
         @(negedge clk);
         if (bus_if.psel_o && !bus_if.penable_o) begin
            wcnt             = (bus_if.paddr_o == wait_addr) ? 3 : 0;
            s_addr           = bus_if.paddr_o;
            s_data           = bus_if.pwdata_o;
            bus_if.pready_i  = 1'b0;
            bus_if.pslverr_i = 1'b0;
         end else if (bus_if.psel_o && bus_if.penable_o) begin
            check("hold_addr", bus_if.paddr_o, s_addr);
            check("hold_data", bus_if.pwdata_o, s_data);
            if (wcnt > 0) begin
               bus_if.pready_i = 1'b0;
               wcnt--;
            end else begin
               bus_if.pready_i  = 1'b1;
               bus_if.pslverr_i = (bus_if.paddr_o == err_addr);
               bus_if.prdata_i  = rd_data;
               if (sb_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_xfer: got addr %h data %h, expected no transfer",
                           bus_if.paddr_o, bus_if.pwdata_o);
               end else begin
                  e = sb_q.pop_front();
                  check("xfer_addr", bus_if.paddr_o, e.addr);
                  check("xfer_data", bus_if.pwdata_o, e.data);
                  check("xfer_write", bus_if.pwrite_o, e.write);
               end
            end
         end else begin
            bus_if.pready_i  = 1'b0;
            bus_if.pslverr_i = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected finish before 200000");
      $fatal(1);
   end

   initial begin
      int n;
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_psel", bus_if.psel_o, 32'd0);
      check("rst_penable", bus_if.penable_o, 32'd0);
      check("rst_paddr", bus_if.paddr_o, 32'd0);
      check("rst_pwdata", bus_if.pwdata_o, 32'd0);
      check("rst_init_done", init_done_o, 32'd0);
      check("rst_busy", busy_o, 32'd0);
      check("rst_err", err_o, 32'd0);
      check("rst_hb_seen", hb_seen_o, 32'd0);
      check("rst_ovif", ovif_o, 32'd0);
      @(negedge clk);
      presetn = 1'b1;

      // Init, zero wait states: init_i sampled at edge N
      push_init();
      pulse_init();
      check("init_gap_psel", bus_if.psel_o, 32'd0);
      tick();
      check("init_setup_psel", bus_if.psel_o, 32'd1);
      check("init_setup_penable", bus_if.penable_o, 32'd0);
      check("init_setup_busy", busy_o, 32'd1);
      check("init_setup_paddr", bus_if.paddr_o, BASE + OFS_KEY);
      repeat (11) tick();
      check("init_done_n12", init_done_o, 32'd0);
      tick();
      check("init_done_n13", init_done_o, 32'd1);
      check("init_busy_n13", busy_o, 32'd0);
      check("init_outstanding", sb_q.size(), 32'd0);

      // Feed gating: three of four requesters only
      @(negedge clk);
      hb_i = 4'b0111;
      @(negedge clk);
      hb_i = 4'b0000;
      repeat (6) tick();
      check("gate_hb_seen", hb_seen_o, 32'h7);
      check("gate_busy", busy_o, 32'd0);

      // Last requester completes the mask; heartbeat 2 collides with launch
      push_feed();
      @(negedge clk);
      hb_i = 4'b1000;
      tick();
      check("feed_mask_full", hb_seen_o, 32'hF);
      @(negedge clk);
      hb_i = 4'b0100;
      tick();
      hb_i = 4'b0000;
      check("feed_collision_mask", hb_seen_o, 32'h4);
      check("feed_gap_psel", bus_if.psel_o, 32'd0);
      repeat (8) tick();
      check("feed_busy_l8", busy_o, 32'd1);
      tick();
      check("feed_busy_l9", busy_o, 32'd0);
      check("feed_outstanding", sb_q.size(), 32'd0);
      check("feed_mask_after", hb_seen_o, 32'h4);

      // Wait states on PSCR, slave error on CMP: no CTRL write follows
      wait_addr = BASE + OFS_PSCR;
      err_addr  = BASE + OFS_CMP;
      push(OFS_KEY, WDG_KEY, 1'b1);
      push(OFS_PSCR, 32'd2, 1'b1);
      push(OFS_KEY, WDG_KEY, 1'b1);
      push(OFS_CMP, 32'hFFFF, 1'b1);
      pulse_init();
      check("reinit_done_clear", init_done_o, 32'd0);
      wait_idle("err_seq", 100);
      check("err_set", err_o, 32'd1);
      check("err_init_done", init_done_o, 32'd0);
      repeat (4) tick();
      check("err_idle_psel", bus_if.psel_o, 32'd0);
      wait_addr = '1;
      err_addr  = '1;

      // Clean re-init clears the error
      push_init();
      pulse_init();
      wait_idle("reinit_seq", 100);
      check("reinit_err_clear", err_o, 32'd0);
      check("reinit_done", init_done_o, 32'd1);

      // Reset during a stretched feed ACCESS: the transfer is dropped
      wait_addr = BASE + OFS_KEY;
      @(negedge clk);
      hb_i = 4'b1011;
      @(negedge clk);
      hb_i = 4'b0000;
      n = 0;
      #1;
      while (!(bus_if.psel_o && bus_if.penable_o) && n < 20) begin
         tick();
         n++;
      end
      check("rstmid_reach_access", bus_if.psel_o && bus_if.penable_o, 32'd1);
      @(negedge clk);
      hb_i = 4'b0001;
      tick();
      hb_i = 4'b0000;
      check("rstmid_pre_mask", hb_seen_o, 32'h1);
      @(negedge clk);
      presetn = 1'b0;
      tick();
      check("rstmid_psel", bus_if.psel_o, 32'd0);
      check("rstmid_penable", bus_if.penable_o, 32'd0);
      check("rstmid_mask", hb_seen_o, 32'd0);
      check("rstmid_init_done", init_done_o, 32'd0);
      check("rstmid_busy", busy_o, 32'd0);
      @(negedge clk);
      presetn   = 1'b1;
      wait_addr = '1;

`ifdef WDG_FEED_CTRL_STAT_CLR_EN
      // STAT read wins over a simultaneously eligible feed
      push_init();
      pulse_init();
      wait_idle("stat_init", 100);
      rd_data = 32'd1;
      push(OFS_STAT, 32'd0, 1'b0);
      push_feed();
      @(negedge clk);
      hb_i = 4'b1111;
      @(negedge clk);
      hb_i  = 4'b0000;
      irq_i = 1'b1;
      tick();
      irq_i = 1'b0;
      wait_idle("stat_then_feed", 100);
      check("stat_ovif", ovif_o, 32'd1);
      check("stat_mask_after", hb_seen_o, 32'd0);
      rd_data = 32'd0;
`endif

      repeat (4) tick();
      check("end_outstanding", sb_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
